// File: rtl/axi_io_pmp_pkg.sv
// Shared types and constants for the IO-PMP AXI error slave.
// Holds the write-path FSM state type, default error response/data constants,
// the read-FIFO entry record, and default AXI channel/request/response structs
// built from the default widths (ID 8, addr 32, data 32, user 1).
package axi_io_pmp_pkg;

  localparam int unsigned AxiIdWidth   = 8;
  localparam int unsigned AxiAddrWidth = 32;
  localparam int unsigned AxiDataWidth = 32;
  localparam int unsigned AxiUserWidth = 1;

  localparam logic [1:0]  ERR_RESP  = 2'b10;  // SLVERR
  localparam logic [31:0] ERR_RDATA = 32'hBADCAB1E;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  // One outstanding read burst: ID to echo and the beat count minus one.
  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [7:0]            len;
  } rd_entry_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [5:0]              atop;
  } aw_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
  } w_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
  } ar_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [1:0]              resp;
    logic [AxiUserWidth-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    logic [AxiUserWidth-1:0] user;
  } r_chan_t;

  typedef struct packed {
    logic     aw_valid;
    aw_chan_t aw;
    logic     w_valid;
    w_chan_t  w;
    logic     b_ready;
    logic     ar_valid;
    ar_chan_t ar;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;

endpackage

// File: rtl/axi_io_pmp_err_slv_fifo.sv
// Synchronous FIFO (fifo_v3 style, fall-through off) used for the write-ID
// and read-ID/len queues of the error slave.
// Ports: clk_i/rst_ni clock and async active-low reset; testmode_i reserved
// for clock gating (no functional effect); push_i/data_i enqueue (ignored
// when full); pop_i/data_o dequeue head (ignored when empty); full_o/empty_o.
module axi_io_pmp_err_slv_fifo #(
  parameter int unsigned Depth = 4,
  parameter type         dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic testmode_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  dtype            mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push, pop;
  logic            unused_testmode;

  assign unused_testmode = testmode_i;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  // A pop never frees a slot for a push in the same cycle.
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/axi_io_pmp_err_slv.sv
// AXI4 error slave on the IO-PMP deny branch: accepts every AW/W/AR burst and
// answers with an error response (Resp) in acceptance order per direction.
// Ports: clk_i, rst_ni (async active-low), test_i (FIFO test mode),
// slv_req_i (AXI request), slv_resp_o (AXI response).
// Build option: AXI_IO_PMP_ERR_ATOP_EN -- an AW with atop[5] set also queues
// an R burst so atomics receive both B and R.
module axi_io_pmp_err_slv
  import axi_io_pmp_pkg::*;
#(
  parameter int unsigned IdWidth   = 8,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned UserWidth = 1,
  parameter int unsigned MaxTxn    = 4,
  parameter logic [1:0]  Resp      = ERR_RESP,
  parameter logic [63:0] RData     = 64'(ERR_RDATA),
  parameter type         req_t     = axi_req_t,
  parameter type         resp_t    = axi_resp_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  test_i,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o
);

  w_state_e           w_state_q, w_state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               wfifo_full, wfifo_empty, wfifo_push, wfifo_pop;
  logic [IdWidth-1:0] wfifo_head;
  logic               rfifo_full, rfifo_empty, rfifo_push, rfifo_pop;
  rd_entry_t          rfifo_din, rfifo_head;
  logic               aw_ready, ar_ready, aw_hs, ar_hs;
  logic               w_ready, b_valid, r_hs, r_last;
  logic               unused_req;

  // Address, data, strobes (and atop when atomics are off) are don't-care.
  assign unused_req = ^slv_req_i;

`ifdef AXI_IO_PMP_ERR_ATOP_EN
  logic aw_atop;
  assign aw_atop  = slv_req_i.aw_valid && slv_req_i.aw.atop[5];
  assign aw_ready = !wfifo_full && !rfifo_full;
  // An atomic AW owns the read-FIFO push port this cycle, so AR waits.
  assign ar_ready = !rfifo_full && !aw_atop;
`else
  assign aw_ready = !wfifo_full;
  assign ar_ready = !rfifo_full;
`endif

  assign aw_hs      = slv_req_i.aw_valid && aw_ready;
  assign ar_hs      = slv_req_i.ar_valid && ar_ready;
  assign wfifo_push = aw_hs;

  always_comb begin
    rfifo_din.id  = slv_req_i.ar.id;
    rfifo_din.len = slv_req_i.ar.len;
    rfifo_push    = ar_hs;
`ifdef AXI_IO_PMP_ERR_ATOP_EN
    if (aw_hs && slv_req_i.aw.atop[5]) begin
      rfifo_din.id  = slv_req_i.aw.id;
      rfifo_din.len = slv_req_i.aw.len;
      rfifo_push    = 1'b1;
    end
`endif
  end

  axi_io_pmp_err_slv_fifo #(
    .Depth (MaxTxn),
    .dtype (logic [IdWidth-1:0])
  ) u_wfifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .testmode_i (test_i),
    .full_o     (wfifo_full),
    .empty_o    (wfifo_empty),
    .data_i     (slv_req_i.aw.id),
    .push_i     (wfifo_push),
    .data_o     (wfifo_head),
    .pop_i      (wfifo_pop)
  );

  axi_io_pmp_err_slv_fifo #(
    .Depth (MaxTxn),
    .dtype (rd_entry_t)
  ) u_rfifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .testmode_i (test_i),
    .full_o     (rfifo_full),
    .empty_o    (rfifo_empty),
    .data_i     (rfifo_din),
    .push_i     (rfifo_push),
    .data_o     (rfifo_head),
    .pop_i      (rfifo_pop)
  );

  // Write path: sink the W burst of the head AW, then return its B.
  always_comb begin
    w_state_d = w_state_q;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    wfifo_pop = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (!wfifo_empty) begin
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (slv_req_i.w_valid && slv_req_i.w.last) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (slv_req_i.b_ready) begin
          wfifo_pop = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read path: stream len+1 beats for the head entry.
  assign r_last    = (cnt_q == rfifo_head.len);
  assign r_hs      = !rfifo_empty && slv_req_i.r_ready;
  assign rfifo_pop = r_hs && r_last;
  assign cnt_d     = !r_hs ? cnt_q : (r_last ? 8'd0 : cnt_q + 8'd1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      cnt_q     <= 8'd0;
    end else begin
      w_state_q <= w_state_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready;
    slv_resp_o.ar_ready = ar_ready;
    slv_resp_o.w_ready  = w_ready;
    slv_resp_o.b_valid  = b_valid;
    slv_resp_o.b.id     = wfifo_head;
    slv_resp_o.b.resp   = Resp;
    slv_resp_o.b.user   = UserWidth'(0);
    slv_resp_o.r_valid  = !rfifo_empty;
    slv_resp_o.r.id     = rfifo_head.id;
    slv_resp_o.r.data   = DataWidth'(RData);
    slv_resp_o.r.resp   = Resp;
    slv_resp_o.r.last   = r_last;
    slv_resp_o.r.user   = UserWidth'(0);
  end

endmodule

// File: tb/tb_axi_io_pmp_err_slv.sv
module tb_axi_io_pmp_err_slv;
  import axi_io_pmp_pkg::*;

  logic      clk;
  logic      rst_n;
  axi_req_t  req;
  axi_resp_t resp;
  int        n_tests = 0;
  int        n_fail = 0;

  typedef struct {
    bit         is_wr;
    logic [7:0] id;
    logic [7:0] len;
    int         exp_beats;
  } vec_t;

  vec_t vecs [6];

  axi_io_pmp_err_slv #(
    .MaxTxn (4)
  ) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .test_i     (1'b0),
    .slv_req_i  (req),
    .slv_resp_o (resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [7:0] len, input logic [5:0] atop);
    int k;
    k = 0;
    req.aw_valid = 1'b1; req.aw.id = id; req.aw.len = len;
    req.aw.atop = atop; req.aw.addr = 32'h4000_0000;
    @(negedge clk);
    while (!resp.aw_ready && k < 50) begin @(negedge clk); k++; end
    if (!resp.aw_ready) chk("aw_ready_timeout", 0, 1);
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [7:0] len, output int waited);
    int k;
    k = 0;
    req.ar_valid = 1'b1; req.ar.id = id; req.ar.len = len; req.ar.addr = 32'h8000_0000;
    @(negedge clk);
    while (!resp.ar_ready && k < 50) begin @(negedge clk); k++; end
    if (!resp.ar_ready) chk("ar_ready_timeout", 0, 1);
    waited = k;
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
  endtask

  task automatic send_w(input int n, input bit last_at_end);
    int k;
    for (int i = 0; i < n; i++) begin
      k = 0;
      req.w_valid = 1'b1; req.w.data = 32'(i); req.w.strb = 4'hf;
      req.w.last = last_at_end && (i == n - 1);
      @(negedge clk);
      while (!resp.w_ready && k < 20) begin @(negedge clk); k++; end
      if (!resp.w_ready) chk("w_ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    req.w_valid = 1'b0; req.w.last = 1'b0;
  endtask

  task automatic recv_b(input logic [7:0] id, input bit imm);
    int k;
    k = 0;
    @(negedge clk);
    if (imm) begin
      chk("b_latency", resp.b_valid, 1);
      chk("w_ready_after_last", resp.w_ready, 0);
    end
    while (!resp.b_valid && k < 20) begin @(negedge clk); k++; end
    chk("b_valid", resp.b_valid, 1);
    chk("b_id", resp.b.id, id);
    chk("b_resp", resp.b.resp, 2'b10);
    chk("b_user", resp.b.user, 0);
    // hold b_ready low one more cycle: B must stay put
    @(negedge clk);
    chk("b_hold_valid", resp.b_valid, 1);
    chk("b_hold_id", resp.b.id, id);
    req.b_ready = 1'b1;
    @(posedge clk); #1;
    req.b_ready = 1'b0;
    @(negedge clk);
    chk("b_valid_after_hs", resp.b_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic recv_r(input logic [7:0] id, input int beats, input bit stall, input bit imm);
    int      got;
    int      k;
    bit      done;
    r_chan_t snap;
    got = 0; done = 1'b0;
    while (!done && got < 300) begin
      k = 0;
      req.r_ready = !stall;
      @(negedge clk);
      while (!resp.r_valid && k < 20) begin @(negedge clk); k++; end
      if (imm && got == 0) chk("r_first_latency", k, 0);
      if (!resp.r_valid) begin
        chk("r_valid_timeout", 0, 1);
        done = 1'b1;
      end else begin
        if (stall) begin
          snap = resp.r;
          @(negedge clk);
          chk("r_stall_valid", resp.r_valid, 1);
          chk("r_stall_payload", 64'(resp.r), 64'(snap));
          req.r_ready = 1'b1;
        end
        chk("r_id", resp.r.id, id);
        chk("r_data", resp.r.data, 32'hBADCAB1E);
        chk("r_resp", resp.r.resp, 2'b10);
        chk("r_user", resp.r.user, 0);
        chk("r_last", resp.r.last, (got == beats - 1));
        done = resp.r.last;
        got++;
        @(posedge clk); #1;
      end
    end
    chk("r_beats", got, beats);
  endtask

  initial begin
    int waited;
    req   = '0;
    rst_n = 1'b0;
    vecs[0] = '{is_wr: 1'b1, id: 8'h12, len: 8'd3,   exp_beats: 4};
    vecs[1] = '{is_wr: 1'b0, id: 8'h05, len: 8'd7,   exp_beats: 8};
    vecs[2] = '{is_wr: 1'b1, id: 8'hff, len: 8'd0,   exp_beats: 1};
    vecs[3] = '{is_wr: 1'b0, id: 8'h00, len: 8'd0,   exp_beats: 1};
    vecs[4] = '{is_wr: 1'b0, id: 8'ha5, len: 8'd255, exp_beats: 256};
    vecs[5] = '{is_wr: 1'b1, id: 8'h01, len: 8'd1,   exp_beats: 2};

    #3;
    chk("rst_aw_ready", resp.aw_ready, 1);
    chk("rst_ar_ready", resp.ar_ready, 1);
    chk("rst_w_ready", resp.w_ready, 0);
    chk("rst_b_valid", resp.b_valid, 0);
    chk("rst_r_valid", resp.r_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // W with no AW outstanding is stalled
    req.w_valid = 1'b1; req.w.last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("w_stall_no_aw", resp.w_ready, 0);
    end
    @(posedge clk); #1;
    req.w_valid = 1'b0; req.w.last = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_wr) begin
        send_aw(vecs[i].id, vecs[i].len, 6'b0);
        send_w(vecs[i].exp_beats, 1'b1);
        recv_b(vecs[i].id, 1'b1);
      end else begin
        send_ar(vecs[i].id, vecs[i].len, waited);
        recv_r(vecs[i].id, vecs[i].exp_beats, 1'b0, 1'b1);
        req.r_ready = 1'b0;
        @(negedge clk);
        chk("r_idle_after_burst", resp.r_valid, 0);
        @(posedge clk); #1;
      end
    end

    // Read FIFO fills at 4; the 5th AR waits for the first burst to drain
    for (int i = 1; i <= 4; i++) send_ar(8'(i), 8'd1, waited);
    @(negedge clk);
    chk("ar_ready_full", resp.ar_ready, 0);
    @(posedge clk); #1;
    fork
      begin
        send_ar(8'h05, 8'd1, waited);
        chk("ar5_wait_cycles", waited, 2);
      end
      begin
        for (int i = 1; i <= 5; i++) recv_r(8'(i), 2, 1'b0, 1'b0);
      end
    join
    req.r_ready = 1'b0;
    @(negedge clk);
    chk("r_idle_after_five", resp.r_valid, 0);
    @(posedge clk); #1;

    // R backpressure: payload holds while r_ready is low
    send_ar(8'h44, 8'd2, waited);
    recv_r(8'h44, 3, 1'b1, 1'b1);
    req.r_ready = 1'b0;
    @(negedge clk);
    chk("r_idle_after_stall", resp.r_valid, 0);
    @(posedge clk); #1;

    // Reset in the middle of a W burst with an R burst pending
    send_aw(8'h21, 8'd3, 6'b0);
    send_ar(8'h33, 8'd3, waited);
    @(negedge clk);
    chk("pre_rst_r_valid", resp.r_valid, 1);
    @(posedge clk); #1;
    send_w(2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_w_ready", resp.w_ready, 0);
    chk("mid_rst_b_valid", resp.b_valid, 0);
    chk("mid_rst_r_valid", resp.r_valid, 0);
    chk("mid_rst_aw_ready", resp.aw_ready, 1);
    chk("mid_rst_ar_ready", resp.ar_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    req.b_ready = 1'b1; req.r_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_b_valid", resp.b_valid, 0);
      chk("post_rst_r_valid", resp.r_valid, 0);
    end
    chk("post_rst_aw_ready", resp.aw_ready, 1);
    chk("post_rst_ar_ready", resp.ar_ready, 1);
    @(posedge clk); #1;
    req.b_ready = 1'b0; req.r_ready = 1'b0;

`ifdef AXI_IO_PMP_ERR_ATOP_EN
    // Atomic AW: both a B and a single-beat R come back
    send_aw(8'h03, 8'd0, 6'b100000);
    send_w(1, 1'b1);
    recv_b(8'h03, 1'b1);
    recv_r(8'h03, 1, 1'b0, 1'b0);
    req.r_ready = 1'b0;
    @(negedge clk);
    chk("atop_r_idle", resp.r_valid, 0);
    @(posedge clk); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
